piggy_top: RTL and testbench
============================

Name: piggy_top

Overview:
- Tiny Tapeout top-level for a coin "piggy bank".
- Four debounced push-buttons each add a fixed coin value (10, 5, 2, 1 baht) to a running 16-bit total.
- A fifth debounced button starts a UART transmission of the total.
- Sits directly on the standard TT user-module pin interface.

Parameters:
- DEBOUNCE_CYCLES, 400000, consecutive stable clock cycles required before a debounced input changes level.
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud).

Ports:
- clk  input  1  system clock, 100 MHz nominal.
- rst_n  input  1  reset; one clock, reset synchronous and active-low.
- ena  input  1  TT enable; ignored.
- ui_in  input  8  [6]=10 baht, [2]=5 baht, [3]=2 baht, [4]=1 baht, [5]=send; [0],[1],[7] unused. All buttons active-high.
- uo_out  output  8  [0]=UART TX (idle 1); [1]=tx_busy; [7:2]=total[5:0].
- uio_in  input  8  unused.
- uio_out  output  8  constant 0.
- uio_oe  output  8  constant 0 (all inputs).

Behaviour:
- Reset (rst_n=0 at a clk edge): total=0, all debounce counters=0, all debounced levels=0, synchronizers=0, UART FSM=IDLE, tx=1, tx_busy=0. Hence uo_out=8'h01.
- Input conditioning:
  - Each of the 5 buttons passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level toggles only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce back to the current level resets the counter to 0.
- Press event: a one-cycle pulse on the rising edge of the debounced level. Release produces no event.
- Coin accumulation:
  - On a press event, total <= total + value in the following cycle.
  - Simultaneous press events in the same cycle are summed, e.g. 10+5 gives +15.
  - Addition saturates at 16'hFFFF; no wrap.
  - The total is never cleared except by reset; sending does not clear it.
- UART TX: 8N1, LSB first, 2 bytes per send, total[15:8] then total[7:0].
  - On a send press event while IDLE, snapshot total into a 16-bit shift buffer and set tx_busy=1 on the next cycle.
  - FSM states: IDLE, START (tx=0), DATA (8 bits), STOP (tx=1), NEXT. Each bit lasts exactly CLKS_PER_BIT cycles.
  - After the second byte's stop bit, return to IDLE and clear tx_busy. There is no inter-byte gap beyond the stop bit.
  - A send press while tx_busy=1 is ignored and not queued.
  - Coins inserted during transmission update total; the in-flight frame carries the snapshot value.
- Reset mid-transmission aborts immediately: tx=1 and IDLE on the next edge.
- Latency from a physical edge to the press pulse: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.

Decomposition:
- Package piggy_pkg holds:
  - coin value constants COIN_10=10, COIN_5=5, COIN_2=2, COIN_1=1;
  - ui_in bit-index constants;
  - the UART state enum;
  - TOTAL_W=16.
- One natural sub-module: piggy_debounce, holding the synchronizer, debounce counter, level and rise pulse, parameterised by DEBOUNCE_CYCLES. It is instantiated 5 times.
- The UART TX and accumulator stay in the top.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> uo_out=8'h01, uio_oe=0, uio_out=0.
- Press 10, 5, 2, 1 in sequence, each held DEBOUNCE_CYCLES+100 cycles then released the same -> total=18, uo_out[7:2]=6'd18.
- Bounce rejection: on ui_in[4], toggle high for DEBOUNCE_CYCLES-1 cycles, low 1 cycle, repeat 5 times -> total unchanged (0).
- Send after 18 baht: press ui_in[5] -> tx_busy=1, then TX frames 0x00 then 0x12. Each frame is 10 bits of CLKS_PER_BIT cycles (20*CLKS_PER_BIT total), after which tx_busy=0 and tx=1.
- Send re-press while busy and a coin mid-send: re-press ignored, only 2 bytes sent; a 1-baht press mid-send -> frame still 0x0012, total afterwards 19.
- Saturation and reset abort:
  - Preload near max via repeated 10-baht presses; use DEBOUNCE_CYCLES=4 and CLKS_PER_BIT=4 in sim -> total clamps at 65535.
  - Assert rst_n=0 mid-frame -> tx=1, total=0 next cycle.

Source files
------------

// File: rtl/piggy_pkg.sv
// Shared constants and types for the coin piggy bank.
// Coin values, button pin map and UART FSM states.
package piggy_pkg;

  localparam int TOTAL_W = 16;

  localparam logic [TOTAL_W-1:0] COIN_10 = 16'd10;
  localparam logic [TOTAL_W-1:0] COIN_5  = 16'd5;
  localparam logic [TOTAL_W-1:0] COIN_2  = 16'd2;
  localparam logic [TOTAL_W-1:0] COIN_1  = 16'd1;

  localparam int BIT_10   = 6;
  localparam int BIT_5    = 2;
  localparam int BIT_2    = 3;
  localparam int BIT_1    = 4;
  localparam int BIT_SEND = 5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    NEXT
  } uart_state_t;

endpackage

// File: rtl/piggy_debounce.sv
// Button conditioning: 2-flop synchronizer, debounce counter,
// debounced level and a one-cycle pulse on its rising edge.
module piggy_debounce #(
  parameter int DEBOUNCE_CYCLES = 400000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      rise <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sync[1];
        rise  <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/piggy_top.sv
// Coin piggy bank: debounced coin buttons feed a saturating total,
// a send button streams the total out as two UART 8N1 bytes.
module piggy_top
  import piggy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 400000,
  parameter int CLKS_PER_BIT    = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CCW = $clog2(CLKS_PER_BIT + 1);

  logic p10, p5, p2, p1, send_ev;

  piggy_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db10 (
    .clk(clk), .rst_n(rst_n), .btn(ui_in[BIT_10]), .rise(p10));
  piggy_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db5 (
    .clk(clk), .rst_n(rst_n), .btn(ui_in[BIT_5]), .rise(p5));
  piggy_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
    .clk(clk), .rst_n(rst_n), .btn(ui_in[BIT_2]), .rise(p2));
  piggy_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
    .clk(clk), .rst_n(rst_n), .btn(ui_in[BIT_1]), .rise(p1));
  piggy_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbs (
    .clk(clk), .rst_n(rst_n), .btn(ui_in[BIT_SEND]), .rise(send_ev));

  logic [TOTAL_W-1:0] total;
  logic [TOTAL_W-1:0] add;
  logic [TOTAL_W:0]   sum;

  always_comb begin
    add = '0;
    if (p10) add = add + COIN_10;
    if (p5)  add = add + COIN_5;
    if (p2)  add = add + COIN_2;
    if (p1)  add = add + COIN_1;
    sum = {1'b0, total} + {1'b0, add};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) total <= '0;
    else        total <= sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
  end

  uart_state_t        state, state_nx;
  logic [TOTAL_W-1:0] shadow;
  logic [CCW-1:0]     clk_cnt;
  logic [CCW-1:0]     bit_end;
  logic [2:0]         bit_idx;
  logic               byte_sel;
  logic               bit_done;
  logic [7:0]         cur_byte;
  logic               tx, busy;

  // First stop bit is one cycle short; NEXT supplies the missing cycle.
  assign bit_end  = (state == STOP && !byte_sel) ?
                    CCW'(CLKS_PER_BIT - 2) : CCW'(CLKS_PER_BIT - 1);
  assign bit_done = (clk_cnt == bit_end);
  assign cur_byte = byte_sel ? shadow[7:0] : shadow[15:8];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (send_ev) state_nx = START;
      START: if (bit_done) state_nx = DATA;
      DATA:  if (bit_done && bit_idx == 3'd7) state_nx = STOP;
      STOP:  if (bit_done) state_nx = byte_sel ? IDLE : NEXT;
      NEXT:  state_nx = START;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow   <= '0;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_sel <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          clk_cnt  <= '0;
          bit_idx  <= '0;
          byte_sel <= 1'b0;
          if (send_ev) shadow <= total;
        end
        NEXT: begin
          clk_cnt  <= '0;
          byte_sel <= 1'b1;
        end
        default: begin
          clk_cnt <= bit_done ? '0 : clk_cnt + 1'b1;
          if (state == DATA && bit_done) bit_idx <= bit_idx + 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    tx   = 1'b1;
    busy = (state != IDLE);
    unique case (state)
      START:   tx = 1'b0;
      DATA:    tx = cur_byte[bit_idx];
      default: tx = 1'b1;
    endcase
  end

  assign uo_out  = {total[5:0], busy, tx};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused;
  assign unused = &{1'b0, ena, uio_in, ui_in[7], ui_in[1:0]};

endmodule

// File: tb/tb_piggy_top.sv
// Directed bench for piggy_top with short debounce and bit times.
// Checks reset, debounce, coin sums, saturation and UART frames.
module tb_piggy_top;

  localparam int D   = 4;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  piggy_top #(.DEBOUNCE_CYCLES(D), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [7:0] m);
    ui_in = ui_in | m;
    repeat (8) tick();
    ui_in = ui_in & ~m;
    repeat (8) tick();
  endtask

  task automatic recv(input logic [7:0] inj, output logic [15:0] data);
    logic [19:0] bits;
    int n;
    n = 0;
    bits = '0;
    ui_in[5] = 1'b1;
    while (uo_out[1] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("busy_rise", {31'd0, uo_out[1]}, 32'd1);
    ui_in[5] = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 20; i++) begin
      bits[i] = uo_out[0];
      if (i == 5)  ui_in = ui_in | inj;
      if (i == 12) ui_in = ui_in & ~inj;
      if (i < 19) repeat (CPB) tick();
    end
    tick();
    chk("busy_last_cycle", {31'd0, uo_out[1]}, 32'd1);
    tick();
    chk("idle_after_frame", {24'd0, uo_out[1:0]}, 32'h1);
    chk("start_stop_bits",
        {28'd0, bits[0], bits[9], bits[10], bits[19]}, 32'b0101);
    data = {bits[8:1], bits[18:11]};
  endtask

  logic [15:0] rx;

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_uo_out", {24'd0, uo_out}, 32'h01);
    chk("reset_uio_oe", {24'd0, uio_oe}, 32'h00);
    chk("reset_uio_out", {24'd0, uio_out}, 32'h00);
    chk("reset_total", {16'd0, dut.total}, 32'd0);

    for (int r = 0; r < 5; r++) begin
      ui_in[4] = 1'b1;
      repeat (D - 1) tick();
      ui_in[4] = 1'b0;
      tick();
    end
    repeat (10) tick();
    chk("bounce_total", {16'd0, dut.total}, 32'd0);

    press(8'h40);
    chk("coin10", {16'd0, dut.total}, 32'd10);
    press(8'h04);
    chk("coin5", {16'd0, dut.total}, 32'd15);
    press(8'h08);
    chk("coin2", {16'd0, dut.total}, 32'd17);
    press(8'h10);
    chk("coin1", {16'd0, dut.total}, 32'd18);
    chk("uo_out_18", {24'd0, uo_out}, 32'h49);

    recv(8'h00, rx);
    chk("frame_18", {16'd0, rx}, 32'h0012);
    chk("total_kept", {16'd0, dut.total}, 32'd18);

    recv(8'h30, rx);
    chk("frame_snapshot", {16'd0, rx}, 32'h0012);
    repeat (30) tick();
    chk("no_queued_send", {31'd0, uo_out[1]}, 32'd0);
    chk("coin_mid_send", {16'd0, dut.total}, 32'd19);

    press(8'h44);
    chk("coin_10_plus_5", {16'd0, dut.total}, 32'd34);

    for (int k = 0; k < 3638; k++) press(8'h5C);
    chk("near_max", {16'd0, dut.total}, 32'd65518);
    press(8'h5C);
    chk("saturate", {16'd0, dut.total}, 32'd65535);
    press(8'h40);
    chk("stay_sat", {16'd0, dut.total}, 32'd65535);
    chk("uo_total_bits", {26'd0, uo_out[7:2]}, 32'd63);

    ui_in[5] = 1'b1;
    begin
      int n;
      n = 0;
      while (uo_out[1] !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
    end
    chk("abort_busy", {31'd0, uo_out[1]}, 32'd1);
    ui_in[5] = 1'b0;
    tick();
    chk("abort_start_bit", {31'd0, uo_out[0]}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_uo_out", {24'd0, uo_out}, 32'h01);
    chk("abort_total", {16'd0, dut.total}, 32'd0);
    repeat (4 * CPB) tick();
    chk("abort_stays_idle", {24'd0, uo_out}, 32'h01);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
